// File: rtl/prm_chk_scan_ctrl.sv
// Purpose: readout sequencer that walks the 64-word sticky edge-result accumulator and streams words out.
// Latency: start to first m_valid is 3 cycles; 3 cycles per emitted word, 2 per skipped zero word.
// Backpressure: valid/ready; an offered word holds m_data/m_index/m_last stable until m_ready is high.
module prm_chk_scan_ctrl #(
  parameter int NUM_BANK       = 4,
  parameter int WORDS_PER_BANK = 16,
  parameter int DATA_W         = 32,
  parameter bit SKIP_ZERO      = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_after_scan,
  output logic [1:0]        sel1,
  output logic [7:0]        sel2,
  input  logic [DATA_W-1:0] result_imp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [5:0]        m_index,
  output logic              m_last,
  output logic              acc_clr,
  output logic              busy,
  output logic              done,
  output logic [6:0]        hit_count
);

  // Index of the final word; it is always emitted so m_last closes every scan.
  localparam logic [5:0] LAST_IDX = 6'(NUM_BANK * WORDS_PER_BANK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CAPT,
    ST_OUT,
    ST_CLR,
    ST_DONE
  } state_t;

  // Captured output beat, kept together so data, index and last move as one.
  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [5:0]        index;
    logic              last;
  } beat_t;

  state_t     state;
  logic [5:0] idx;
  logic       clr_flag;
  beat_t      beat_q;

  // Accumulator address comes straight from the index register: upper bits pick the bank, lower the word.
  assign sel1 = idx[5:4];
  assign sel2 = {4'b0000, idx[3:0]};

  assign m_data  = beat_q.dat;
  assign m_index = beat_q.index;
  assign m_last  = beat_q.last;

  // Scan FSM with registered outputs; abort overrides everything except reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      clr_flag  <= 1'b0;
      beat_q    <= '0;
      m_valid   <= 1'b0;
      acc_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_count <= '0;
    end else if (abort) begin
      // Partial hit_count and idx are left as they are; no done or clear is issued.
      state   <= ST_IDLE;
      m_valid <= 1'b0;
      acc_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done    <= 1'b0;
          acc_clr <= 1'b0;
          if (start) begin
            state     <= ST_SEL;
            idx       <= '0;
            hit_count <= '0;
            clr_flag  <= clr_after_scan;
            busy      <= 1'b1;
          end
        end

        // One cycle for the accumulator mux to settle on the new sel1/sel2.
        ST_SEL: begin
          state <= ST_CAPT;
        end

        ST_CAPT: begin
          beat_q.dat   <= result_imp;
          beat_q.index <= idx;
          beat_q.last  <= (idx == LAST_IDX);
          if (result_imp != '0) begin
            hit_count <= hit_count + 7'd1;
          end
          if (SKIP_ZERO && (result_imp == '0) && (idx != LAST_IDX)) begin
            idx   <= idx + 6'd1;
            state <= ST_SEL;
          end else begin
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end
        end

        // Hold the beat until downstream takes it, then advance or wrap up.
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (idx != LAST_IDX) begin
              idx   <= idx + 6'd1;
              state <= ST_SEL;
            end else if (clr_flag) begin
              acc_clr <= 1'b1;
              state   <= ST_CLR;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_CLR: begin
          acc_clr <= 1'b0;
          done    <= 1'b1;
          state   <= ST_DONE;
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          m_valid <= 1'b0;
          acc_clr <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/prm_chk_scan_ctrl.md
Name: prm_chk_scan_ctrl

Overview:
Readout sequencer for the 2048-bit sticky edge-result accumulator. Steps the accumulator's bank select (sel1) and word select (sel2) across all 64 32-bit words, registers each returned word, and streams it out on a valid/ready interface with its word index. Optionally skips all-zero words, counts non-zero words, and issues a one-cycle accumulator clear when a scan completes.

Parameters:
NUM_BANK, 4, number of 512-bit banks selected by sel1
WORDS_PER_BANK, 16, 32-bit words per bank selected by sel2
DATA_W, 32, readout word width
SKIP_ZERO, 1, 1 = zero words other than the final word are not emitted

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
start  in  1  begin scan; sampled only in IDLE
abort  in  1  terminate scan; valid in any state
clr_after_scan  in  1  sampled with start; 1 = pulse acc_clr after the last word
sel1  out  2  bank select to accumulator
sel2  out  8  word select to accumulator; bits [7:4] always 0
result_imp  in  32  combinational word from accumulator for current sel1/sel2
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  32  captured word
m_index  out  6  word index = {sel1, sel2[3:0]} at capture
m_last  out  1  high with word 63
acc_clr  out  1  one-cycle clear request to accumulator
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal scan completion
hit_count  out  7  non-zero words seen in the current or last scan (0..64)

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE, idx=0, sel1=0, sel2=0, m_valid=0, m_data=0, m_index=0, m_last=0, acc_clr=0, busy=0, done=0, hit_count=0, clr flag=0. Reset mid-scan has the same effect; no done pulse and no acc_clr.
- States: IDLE, SEL, CAPT, OUT, CLR, DONE.
- IDLE: on start=1, go to SEL, set idx=0, clear hit_count, latch clr_after_scan. start in any other state is ignored.
- sel1=idx[5:4] and sel2={4'b0,idx[3:0]}, driven from registers in every state.
- SEL: one settle cycle, then go to CAPT.
- CAPT: register result_imp into m_data and idx into m_index. If result_imp!=0, increment hit_count. If SKIP_ZERO=1, result_imp==0 and idx!=63: idx+=1 and go to SEL. Otherwise go to OUT.
- OUT: m_valid=1. m_data, m_index and m_last (idx==63) stay stable until m_ready=1. On the accepting edge, m_valid falls.
  - idx<63: idx+=1 and go to SEL.
  - idx==63: go to CLR if the clr flag is set, else go to DONE.
- Word 63 is always emitted, including when it is zero, so m_last always terminates a scan.
- CLR: acc_clr=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. hit_count holds until the next start.
- Latency: start to first m_valid is 3 cycles when word 0 is non-zero (SEL, CAPT, OUT).
- Throughput: 3 cycles per emitted word with m_ready held high; 2 cycles per skipped word.
- Total scan length:
  - Full scan, no skip, m_ready=1: 64*3 cycles, plus 1 cycle if CLR, plus 1 cycle DONE.
  - Empty scan with SKIP_ZERO=1: 63*2 + 3 cycles, plus CLR, plus DONE.
- abort=1: the next state is IDLE from any state, m_valid drops immediately, there is no done or acc_clr, and hit_count keeps its partial value. abort has priority over m_ready and start in the same cycle. RST has priority over abort.
- The idx counter never wraps inside a scan. hit_count cannot exceed 64, so it needs no saturation.

Test Plan:
- Reset, then start with SKIP_ZERO=1 and an accumulator of all zeros -> exactly one beat: m_index=63, m_data=0, m_last=1. Then done pulses, hit_count=0, and the scan takes 131 cycles from start to done.
- Accumulator bits 0, 600 and 2047 set, SKIP_ZERO=1, clr_after_scan=1, m_ready=1 -> beats idx0 0x00000001, idx18 0x01000000, idx63 0x80000000 with m_last. acc_clr pulses once before done, and hit_count=3.
- All ones, SKIP_ZERO=0, m_ready toggling 1 cycle high / 2 cycles low -> 64 beats with idx 0..63 in order. m_data/m_index stay stable while stalled, and no beat is lost or duplicated.
- Assert abort during the stall on idx 18 -> m_valid=0 next cycle, busy=0, no done, no acc_clr. A following start restarts at idx 0.
- Pulse start while busy -> ignored, and the scan sequence is unchanged. Assert RST mid-OUT -> all outputs return to reset values on the next edge.
- clr_after_scan=0 -> acc_clr stays 0 throughout, and done still pulses exactly one cycle after the last beat is accepted.
